pipe_scheduler: RTL and testbench
=================================

# pipe_scheduler

Sequences the pipe obstacle datapath for the flappy-bird game. Owns two pipe slots: spawns pipes at a fixed frame interval with LFSR-chosen gap heights, scrolls them left on each frame tick, retires them off-screen, and scores each pipe the bird clears. Sits between the frame-tick source and `game_controller`: it supplies the nearest pipe's x/gap for collision, and both slots for the renderer.

## Interface
- SCREEN_WIDTH, 640, visible width in pixels; also the spawn x.
- SCREEN_HEIGHT, 480, visible height in pixels.
- PIPE_WIDTH, 50, pipe width in pixels.
- PIPE_GAP, 100, vertical gap size (informational; gap centre range below respects it).
- BIRD_X, 100, bird left x, used for scoring.
- PIPE_SPEED, 2, pixels moved per frame tick.
- SPAWN_FRAMES, 180, frame ticks between spawns.
- GAP_MIN, 110, minimum gap-centre y; gap_y = GAP_MIN + lfsr[7:0].
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_state  in  2  0 IDLE, 1 PLAYING, 2 GAME_OVER, 3 treated as IDLE.
- pipe0_x, pipe1_x  out  10 each  slot left-edge x.
- pipe0_gap_y, pipe1_gap_y  out  10 each  slot gap-centre y.
- pipe_valid  out  2  per-slot valid.
- nearest_x  out  10  left x of nearest unpassed valid pipe.
- nearest_gap_y  out  10  its gap-centre y.
- nearest_valid  out  1  nearest pipe exists.
- score  out  8  pipes cleared, saturating at 255.
- score_pulse  out  1  one-cycle pulse per increment.
- spawn_overflow  out  1  sticky: a spawn was skipped because both slots were busy.

## Operation
- Internal states IDLE, RUN, FREEZE, selected from game_state each cycle: 0/3 -> IDLE, 1 -> RUN, 2 -> FREEZE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, steps every clk in all states, never zero.
- IDLE: pipe_valid=0, passed flags cleared, slot x=SCREEN_WIDTH, gap_y=SCREEN_HEIGHT/2, score=0, spawn_overflow=0, spawn counter preloaded to SPAWN_FRAMES-1.
- RUN, per frame_tick, in this order:
  - Each valid slot: if x < PIPE_SPEED, retire (valid=0); else x -= PIPE_SPEED. A slot spawned on this tick does not move.
  - Scoring: a valid, unpassed slot whose post-move x+PIPE_WIDTH < BIRD_X sets passed, score += 1 (saturating), score_pulse=1. Both slots scoring on one tick add 2 and produce a single pulse.
  - Spawn counter: if == SPAWN_FRAMES-1, clear to 0 and spawn into the lowest-index free slot (a slot retired this tick counts as free), with x=SCREEN_WIDTH, gap_y=GAP_MIN+lfsr[7:0], passed=0. If no slot is free, skip the spawn and set spawn_overflow. Otherwise increment the counter.
  - The first tick after entering RUN spawns, because of the preload.
- FREEZE: all state held, frame_tick ignored, LFSR still steps.
- Nearest pipe: among valid, unpassed slots, the one with the smaller x (slot 0 on a tie). If none: nearest_valid=0, nearest_x=SCREEN_WIDTH, nearest_gap_y=SCREEN_HEIGHT/2.
- Arithmetic is 10-bit unsigned; comparisons are done at 11 bits so that x+PIPE_WIDTH cannot wrap.

## Timing
- All outputs are registered. Effects of a frame_tick at cycle N are visible at cycle N+1. The nearest_* outputs are registered from next-state values, so they are also valid at N+1.
- score_pulse is high for exactly one cycle, N+1.
- A frame_tick in the same cycle as a game_state change is processed under the new state.
- A reset assertion at any time clears to the IDLE values immediately, with no clock needed; LFSR returns to seed.
- A frame_tick held for several cycles counts once per high cycle. The bench drives single-cycle pulses only.

## Test plan
- Reset low mid-RUN with pipes active -> at once pipe_valid=0, score=0, nearest_valid=0, LFSR=16'hACE1.
- game_state=1, then frame_tick #1 -> pipe_valid=2'b01, pipe0_x=640, pipe0_gap_y=110+lfsr[7:0] sampled that cycle. After tick #2, pipe0_x=638.
- Continue ticks -> score_pulse and score=1 on tick #297 (pipe0_x=48). Pipe0 retires on tick #322. Pipe1 spawns on tick #181.
- SPAWN_FRAMES=100 -> ticks #1 and #101 fill both slots. Tick #201 is skipped: spawn_overflow=1 and pipe_valid stays 2'b11.
- game_state=2 mid-run, 10 ticks -> pipe x and score unchanged. Return to 1 -> movement resumes at the next tick.
- game_state=0 after score=5 -> score=0, slots cleared. Re-entering 1 spawns on the first tick.

Source files
------------

// File: rtl/pipe_scheduler_if.sv
// Pipe scheduler bus: frame/game-state inputs plus pipe slot, nearest-pipe and score outputs.
// Ports: frame_tick, game_state in; pipe0/1 x+gap, pipe_valid, nearest_*, score, score_pulse, spawn_overflow out.
// No handshake: every output is a registered level sampled by game_controller and the renderer.
interface pipe_scheduler_if;
    logic       frame_tick;
    logic [1:0] game_state;
    logic [9:0] pipe0_x;
    logic [9:0] pipe1_x;
    logic [9:0] pipe0_gap_y;
    logic [9:0] pipe1_gap_y;
    logic [1:0] pipe_valid;
    logic [9:0] nearest_x;
    logic [9:0] nearest_gap_y;
    logic       nearest_valid;
    logic [7:0] score;
    logic       score_pulse;
    logic       spawn_overflow;

    // master drives the frame tick and game state; slave is the scheduler itself
    modport master (
        output frame_tick, game_state,
        input  pipe0_x, pipe1_x, pipe0_gap_y, pipe1_gap_y, pipe_valid,
               nearest_x, nearest_gap_y, nearest_valid,
               score, score_pulse, spawn_overflow
    );

    modport slave (
        input  frame_tick, game_state,
        output pipe0_x, pipe1_x, pipe0_gap_y, pipe1_gap_y, pipe_valid,
               nearest_x, nearest_gap_y, nearest_valid,
               score, score_pulse, spawn_overflow
    );
endinterface

// File: rtl/pipe_scheduler.sv
// Two-slot pipe scheduler: spawns, scrolls, retires and scores pipes on frame ticks.
// Latency: every output is registered; the effect of a tick in cycle N is visible in cycle N+1.
// No backpressure: frame_tick is consumed every cycle it is high; a spawn with no free slot is dropped and flagged.
// Ports: clk, reset (async, active-low), bus (pipe_scheduler_if.slave).
module pipe_scheduler #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PIPE_WIDTH    = 50,
    parameter int PIPE_GAP      = 100,
    parameter int BIRD_X        = 100,
    parameter int PIPE_SPEED    = 2,
    parameter int SPAWN_FRAMES  = 180,
    parameter int GAP_MIN       = 110
) (
    input  logic             clk,
    input  logic             reset,
    pipe_scheduler_if.slave  bus
);
    localparam int              CW        = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SPAWN_FRAMES - 1);
    localparam logic [9:0]      X_SPAWN   = 10'(SCREEN_WIDTH);
    localparam logic [9:0]      Y_MID     = 10'(SCREEN_HEIGHT / 2);
    localparam logic [9:0]      SPEED     = 10'(PIPE_SPEED);
    localparam logic [9:0]      GAP_BASE  = 10'(GAP_MIN);
    localparam logic [10:0]     PW11      = 11'(PIPE_WIDTH);
    localparam logic [10:0]     BX11      = 11'(BIRD_X);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;
    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0]     LFSR_TAPS = 16'hB400;

    // The widest gap (GAP_MIN+255) with half the gap either side must stay on screen.
    if ((GAP_MIN < PIPE_GAP / 2) || (GAP_MIN + 255 + PIPE_GAP / 2 > SCREEN_HEIGHT)) begin : g_gap_range_bad
        $error("pipe_scheduler: gap centre range does not fit the screen");
    end

    typedef enum logic [1:0] {MODE_IDLE, MODE_RUN, MODE_FREEZE} mode_e;
    mode_e mode;

    logic [1:0][9:0] x_q, x_d, gap_q, gap_d;
    logic [1:0]      vld_q, vld_d, passed_q, passed_d;
    logic [7:0]      score_q, score_d;
    logic            pulse_q, pulse_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [9:0]      near_x_q, near_x_d, near_gap_q, near_gap_d;
    logic            near_vld_q, near_vld_d;
    logic [1:0]      inc;
    logic [8:0]      score_sum;
    logic [1:0]      cand;

    // Mode follows game_state combinationally so a tick coinciding with a state change uses the new state.
    always_comb begin
        mode = MODE_IDLE;
        unique case (bus.game_state)
            2'd1:    mode = MODE_RUN;
            2'd2:    mode = MODE_FREEZE;
            default: mode = MODE_IDLE;
        endcase
    end

    always_comb begin
        x_d        = x_q;
        gap_d      = gap_q;
        vld_d      = vld_q;
        passed_d   = passed_q;
        score_d    = score_q;
        pulse_d    = 1'b0;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        inc        = 2'd0;
        score_sum  = 9'd0;
        cand       = 2'b00;
        near_vld_d = 1'b0;
        near_x_d   = X_SPAWN;
        near_gap_d = Y_MID;
        // LFSR free-runs in every mode
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        unique case (mode)
            MODE_IDLE: begin
                x_d      = {X_SPAWN, X_SPAWN};
                gap_d    = {Y_MID, Y_MID};
                vld_d    = 2'b00;
                passed_d = 2'b00;
                score_d  = 8'd0;
                ovf_d    = 1'b0;
                cnt_d    = CNT_LAST;
            end
            MODE_RUN: begin
                if (bus.frame_tick) begin
                    // scroll, retiring any slot that would move past x=0
                    for (int i = 0; i < 2; i++) begin
                        if (vld_q[i]) begin
                            if (x_q[i] < SPEED) vld_d[i] = 1'b0;
                            else                x_d[i] = x_q[i] - SPEED;
                        end
                    end
                    // score on post-move position; 11-bit compare so x+width cannot wrap
                    for (int i = 0; i < 2; i++) begin
                        if (vld_d[i] && !passed_q[i] && (({1'b0, x_d[i]} + PW11) < BX11)) begin
                            passed_d[i] = 1'b1;
                            inc         = inc + 2'd1;
                        end
                    end
                    score_sum = {1'b0, score_q} + {7'd0, inc};
                    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                    pulse_d   = (inc != 2'd0);
                    // spawn after the move so a fresh pipe stays at the right edge this tick
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!vld_d[0]) begin
                            vld_d[0]    = 1'b1;
                            x_d[0]      = X_SPAWN;
                            gap_d[0]    = GAP_BASE + {2'b00, lfsr_q[7:0]};
                            passed_d[0] = 1'b0;
                        end else if (!vld_d[1]) begin
                            vld_d[1]    = 1'b1;
                            x_d[1]      = X_SPAWN;
                            gap_d[1]    = GAP_BASE + {2'b00, lfsr_q[7:0]};
                            passed_d[1] = 1'b0;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ; // freeze: hold everything
        endcase

        // nearest pipe from next-state so it lines up with the slot outputs
        cand = vld_d & ~passed_d;
        if (cand[0] && (!cand[1] || (x_d[0] <= x_d[1]))) begin
            near_vld_d = 1'b1;
            near_x_d   = x_d[0];
            near_gap_d = gap_d[0];
        end else if (cand[1]) begin
            near_vld_d = 1'b1;
            near_x_d   = x_d[1];
            near_gap_d = gap_d[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q        <= {X_SPAWN, X_SPAWN};
            gap_q      <= {Y_MID, Y_MID};
            vld_q      <= 2'b00;
            passed_q   <= 2'b00;
            score_q    <= 8'd0;
            pulse_q    <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= CNT_LAST;
            lfsr_q     <= LFSR_SEED;
            near_x_q   <= X_SPAWN;
            near_gap_q <= Y_MID;
            near_vld_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            gap_q      <= gap_d;
            vld_q      <= vld_d;
            passed_q   <= passed_d;
            score_q    <= score_d;
            pulse_q    <= pulse_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            near_x_q   <= near_x_d;
            near_gap_q <= near_gap_d;
            near_vld_q <= near_vld_d;
        end
    end

    assign bus.pipe0_x        = x_q[0];
    assign bus.pipe1_x        = x_q[1];
    assign bus.pipe0_gap_y    = gap_q[0];
    assign bus.pipe1_gap_y    = gap_q[1];
    assign bus.pipe_valid     = vld_q;
    assign bus.nearest_x      = near_x_q;
    assign bus.nearest_gap_y  = near_gap_q;
    assign bus.nearest_valid  = near_vld_q;
    assign bus.score          = score_q;
    assign bus.score_pulse    = pulse_q;
    assign bus.spawn_overflow = ovf_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: two instances (spawn interval 180 and 100) share one stimulus stream.
// Latency: outputs compared at the falling edge after each rising edge against a behavioural model.
// No backpressure: stimulus is a frame_tick/game_state pattern, directed then randomized.
module tb_pipe_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_scheduler_if ifa();
    pipe_scheduler_if ifb();

    pipe_scheduler dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));
    pipe_scheduler #(.SPAWN_FRAMES(100)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));

    // behavioural model state, index [instance][slot]
    int        m_x[2][2];
    int        m_g[2][2];
    bit        m_v[2][2];
    bit        m_p[2][2];
    int        m_cnt[2];
    int        m_score[2];
    bit        m_pulse[2];
    bit        m_ovf[2];
    bit [15:0] m_lfsr[2];

    int n_vec = 0;
    int n_err = 0;
    int tc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int spawn_frames(input int k);
        return (k == 0) ? 180 : 100;
    endfunction

    function automatic bit [15:0] lfsr_next(input bit [15:0] v);
        bit [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_clear(input int k);
        for (int s = 0; s < 2; s++) begin
            m_x[k][s] = 640; m_g[k][s] = 240; m_v[k][s] = 0; m_p[k][s] = 0;
        end
        m_score[k] = 0;
        m_ovf[k]   = 0;
        m_pulse[k] = 0;
        m_cnt[k]   = spawn_frames(k) - 1;
    endtask

    task automatic model_reset(input int k);
        model_clear(k);
        m_lfsr[k] = 16'hACE1;
    endtask

    task automatic model_clock(input int k, input bit tk, input logic [1:0] gs);
        int gained;
        int slot;
        m_pulse[k] = 0;
        if (gs == 2'd0 || gs == 2'd3) begin
            model_clear(k);
        end else if (gs == 2'd1 && tk) begin
            for (int s = 0; s < 2; s++)
                if (m_v[k][s]) begin
                    if (m_x[k][s] < 2) m_v[k][s] = 0;
                    else               m_x[k][s] -= 2;
                end
            gained = 0;
            for (int s = 0; s < 2; s++)
                if (m_v[k][s] && !m_p[k][s] && m_x[k][s] + 50 < 100) begin
                    m_p[k][s] = 1;
                    gained++;
                end
            if (gained > 0) begin
                m_score[k] = (m_score[k] + gained > 255) ? 255 : m_score[k] + gained;
                m_pulse[k] = 1;
            end
            if (m_cnt[k] == spawn_frames(k) - 1) begin
                m_cnt[k] = 0;
                slot = -1;
                for (int s = 1; s >= 0; s--) if (!m_v[k][s]) slot = s;
                if (slot < 0) m_ovf[k] = 1;
                else begin
                    m_v[k][slot] = 1;
                    m_p[k][slot] = 0;
                    m_x[k][slot] = 640;
                    m_g[k][slot] = 110 + int'(m_lfsr[k][7:0]);
                end
            end else begin
                m_cnt[k]++;
            end
        end
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
    endtask

    task automatic check_inst(input int k, input string nm,
                              input logic [9:0] x0, input logic [9:0] x1,
                              input logic [9:0] g0, input logic [9:0] g1,
                              input logic [1:0] v, input logic [9:0] nx,
                              input logic [9:0] ng, input logic nv,
                              input logic [7:0] sc, input logic sp, input logic ov);
        int best;
        int ex_nx, ex_ng;
        best = -1;
        for (int s = 0; s < 2; s++)
            if (m_v[k][s] && !m_p[k][s] && (best < 0 || m_x[k][s] < m_x[k][best])) best = s;
        ex_nx = (best < 0) ? 640 : m_x[k][best];
        ex_ng = (best < 0) ? 240 : m_g[k][best];
        chk({nm, ".pipe0_x"},        x0, m_x[k][0]);
        chk({nm, ".pipe1_x"},        x1, m_x[k][1]);
        chk({nm, ".pipe0_gap_y"},    g0, m_g[k][0]);
        chk({nm, ".pipe1_gap_y"},    g1, m_g[k][1]);
        chk({nm, ".pipe_valid"},     v,  {m_v[k][1], m_v[k][0]});
        chk({nm, ".nearest_x"},      nx, ex_nx);
        chk({nm, ".nearest_gap_y"},  ng, ex_ng);
        chk({nm, ".nearest_valid"},  nv, (best >= 0));
        chk({nm, ".score"},          sc, m_score[k]);
        chk({nm, ".score_pulse"},    sp, m_pulse[k]);
        chk({nm, ".spawn_overflow"}, ov, m_ovf[k]);
    endtask

    task automatic check_all();
        check_inst(0, "a", ifa.pipe0_x, ifa.pipe1_x, ifa.pipe0_gap_y, ifa.pipe1_gap_y, ifa.pipe_valid,
                   ifa.nearest_x, ifa.nearest_gap_y, ifa.nearest_valid, ifa.score, ifa.score_pulse,
                   ifa.spawn_overflow);
        check_inst(1, "b", ifb.pipe0_x, ifb.pipe1_x, ifb.pipe0_gap_y, ifb.pipe1_gap_y, ifb.pipe_valid,
                   ifb.nearest_x, ifb.nearest_gap_y, ifb.nearest_valid, ifb.score, ifb.score_pulse,
                   ifb.spawn_overflow);
    endtask

    // one clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
    task automatic step(input bit tk, input logic [1:0] gs);
        ifa.frame_tick = tk;  ifb.frame_tick = tk;
        ifa.game_state = gs;  ifb.game_state = gs;
        @(posedge clk);
        if (rst_n) begin
            model_clock(0, tk, gs);
            model_clock(1, tk, gs);
        end
        @(negedge clk);
        ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0;
        check_all();
    endtask

    initial begin
        logic [1:0] gs;
        int len, r;
        rst_n = 1'b1;
        ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0;
        ifa.game_state = 2'd0; ifb.game_state = 2'd0;
        model_reset(0);
        model_reset(1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_all();
        chk("reset.pipe_valid", ifa.pipe_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'd0);

        // continuous play with irregular tick spacing
        tc = 0;
        while (tc < 330) begin
            for (int i = $urandom_range(0, 2); i > 0; i--) step(1'b0, 2'd1);
            step(1'b1, 2'd1);
            tc++;
            if (tc == 1)   begin chk("t1.valid", ifa.pipe_valid, 1); chk("t1.x0", ifa.pipe0_x, 640); end
            if (tc == 2)   chk("t2.x0", ifa.pipe0_x, 638);
            if (tc == 181) begin chk("t181.valid", ifa.pipe_valid, 3); chk("t181.x1", ifa.pipe1_x, 640); end
            if (tc == 296) chk("t296.score", ifa.score, 0);
            if (tc == 297) begin
                chk("t297.score", ifa.score, 1);
                chk("t297.pulse", ifa.score_pulse, 1);
                chk("t297.x0", ifa.pipe0_x, 48);
            end
            if (tc == 321) chk("t321.valid0", ifa.pipe_valid[0], 1);
            if (tc == 322) chk("t322.valid0", ifa.pipe_valid[0], 0);
            if (tc == 200) chk("b.t200.ovf", ifb.spawn_overflow, 0);
            if (tc == 201) begin chk("b.t201.ovf", ifb.spawn_overflow, 1); chk("b.t201.valid", ifb.pipe_valid, 3); end
        end

        // freeze: ticks ignored, then movement resumes
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'd2);
            step(1'b0, 2'd2);
        end
        chk("frz.x1", ifa.pipe1_x, 342);
        chk("frz.score", ifa.score, 1);
        step(1'b1, 2'd1);
        chk("resume.x1", ifa.pipe1_x, 340);

        // back to idle, then re-enter play
        step(1'b0, 2'd0);
        chk("idle.valid", ifa.pipe_valid, 0);
        chk("idle.score", ifa.score, 0);
        step(1'b1, 2'd1);
        chk("reenter.valid", ifa.pipe_valid, 1);
        chk("reenter.x0", ifa.pipe0_x, 640);

        // randomized segments of game states with random ticks
        for (int seg = 0; seg < 14; seg++) begin
            r  = $urandom_range(0, 99);
            gs = (r < 70) ? 2'd1 : (r < 85) ? 2'd2 : (r < 95) ? 2'd0 : 2'd3;
            len = (gs == 2'd1) ? $urandom_range(50, 700) : $urandom_range(1, 40);
            for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)), gs);
        end

        // asynchronous reset in the middle of a run with pipes active
        for (int i = 0; i < 200; i++) step(1'b1, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", ifa.pipe_valid, 0);
        chk("arst.score", ifa.score, 0);
        chk("arst.nearest_valid", ifa.nearest_valid, 0);
        chk("arst.b.valid", ifb.pipe_valid, 0);
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b1, 2'd1);
        // seed 16'hACE1: first gap is 110 + 8'hE1
        chk("arst.gap0", ifa.pipe0_gap_y, 335);
        for (int i = 0; i < 50; i++) step(1'($urandom_range(0, 1)), 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
